lc4_insn_mem_responder: RTL and testbench

LC4_INSN_MEM_RESPONDER -- requirements
Module: lc4_insn_mem_responder

---
 rtl/lc4_mem_pkg.sv | 25 ++
 rtl/lc4_delay_line.sv | 36 +++
 rtl/lc4_insn_mem_responder.sv | 92 +++++++++
 tb/tb_lc4_insn_mem_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lc4_mem_pkg.sv
// lc4_mem_pkg: shared constants and the pipeline payload type for the LC4
// instruction-memory responder.
//   LC4_WORD_W          : memory word width (16)
//   LC4_DEFAULT_LATENCY : default request-to-response latency (8)
//   LC4_MAX_LATENCY     : largest legal latency (16)
//   imem_stage_t        : one pipeline stage {valid, [addr], data}
// Optional feature macro: LC4_IMEM_RESP_ADDR_EN adds the request address to
// the payload so it can be returned alongside the data.
package lc4_mem_pkg;

  localparam int unsigned LC4_WORD_W          = 16;
  localparam int unsigned LC4_DEFAULT_LATENCY = 8;
  localparam int unsigned LC4_MAX_LATENCY     = 16;

  // Payload carried through the response pipeline; data/addr are zero whenever
  // valid is low so the last stage can drive the outputs directly.
  typedef struct packed {
    logic                  valid;
`ifdef LC4_IMEM_RESP_ADDR_EN
    logic [LC4_WORD_W-1:0] addr;
`endif
    logic [LC4_WORD_W-1:0] data;
  } imem_stage_t;

endpackage

// File: rtl/lc4_delay_line.sv
// lc4_delay_line: fixed-depth shift register with a shared enable.
//   clk  : clock, rising edge
//   rst  : synchronous active-high clear of every stage (wins over i_en)
//   i_en : advance the line by one stage; when low all stages hold
//   i_d  : value entering stage 0
//   o_q  : value leaving the last stage (registered)
module lc4_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift register; reset zeroes payload too so outputs read 0 when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_stage[i] <= '0;
      end
    end else if (i_en) begin
      r_stage[0] <= i_d;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/lc4_insn_mem_responder.sv
// lc4_insn_mem_responder: LC4 instruction memory with a fixed-latency,
// non-back-pressured read pipeline and a program-loader write port.
//   clk        : clock, rising edge
//   rst        : synchronous active-high; clears in-flight responses only
//   gwe        : global write enable; low freezes pipeline and memory
//   req_valid  : read request present this cycle
//   mem_iaddr  : read word address (bits at and above ADDR_W ignored)
//   mem_idata  : read data, 0 when resp_valid is low
//   resp_addr  : request address, 0 when resp_valid is low
//                (only with LC4_IMEM_RESP_ADDR_EN defined)
//   resp_valid : response present, one cycle per request, LATENCY gwe edges
//                after acceptance
//   ld_we/ld_addr/ld_data : loader write port
// Optional feature macro: LC4_IMEM_RESP_ADDR_EN.
module lc4_insn_mem_responder
  import lc4_mem_pkg::*;
#(
  parameter int unsigned LATENCY = LC4_DEFAULT_LATENCY,
  parameter int unsigned ADDR_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gwe,
  input  logic                  req_valid,
  input  logic [LC4_WORD_W-1:0] mem_iaddr,
  output logic [LC4_WORD_W-1:0] mem_idata,
`ifdef LC4_IMEM_RESP_ADDR_EN
  output logic [LC4_WORD_W-1:0] resp_addr,
`endif
  output logic                  resp_valid,
  input  logic                  ld_we,
  input  logic [LC4_WORD_W-1:0] ld_addr,
  input  logic [LC4_WORD_W-1:0] ld_data
);

  localparam int unsigned DEPTH_WORDS = 1 << ADDR_W;

  if (LATENCY < 1 || LATENCY > LC4_MAX_LATENCY) begin : g_bad_latency
    $error("lc4_insn_mem_responder: LATENCY must be 1..16");
  end
  if (ADDR_W < 1 || ADDR_W > LC4_WORD_W) begin : g_bad_addr_w
    $error("lc4_insn_mem_responder: ADDR_W must be 1..16");
  end

  logic [LC4_WORD_W-1:0] r_mem [DEPTH_WORDS];
  logic [ADDR_W-1:0]     w_rd_idx;
  logic [ADDR_W-1:0]     w_wr_idx;
  imem_stage_t           w_stage_in;
  imem_stage_t           w_stage_out;

  assign w_rd_idx = mem_iaddr[ADDR_W-1:0];
  assign w_wr_idx = ld_addr[ADDR_W-1:0];

  // Stage-0 payload: the array is read combinationally here, so a write on the
  // same edge lands after capture and the request sees the old word.
  always_comb begin
    w_stage_in       = '0;
    w_stage_in.valid = req_valid;
    if (req_valid) begin
      w_stage_in.data = r_mem[w_rd_idx];
`ifdef LC4_IMEM_RESP_ADDR_EN
      w_stage_in.addr = mem_iaddr;
`endif
    end
  end

  // Loader write port; the array is deliberately not reset so a program
  // survives rst.
  always_ff @(posedge clk) begin
    if (!rst && gwe && ld_we) begin
      r_mem[w_wr_idx] <= ld_data;
    end
  end

  lc4_delay_line #(
    .DEPTH (LATENCY),
    .WIDTH ($bits(imem_stage_t))
  ) u_resp_pipe (
    .clk  (clk),
    .rst  (rst),
    .i_en (gwe),
    .i_d  (w_stage_in),
    .o_q  (w_stage_out)
  );

  assign resp_valid = w_stage_out.valid;
  assign mem_idata  = w_stage_out.data;
`ifdef LC4_IMEM_RESP_ADDR_EN
  assign resp_addr  = w_stage_out.addr;
`endif

endmodule

// File: tb/tb_lc4_insn_mem_responder.sv
// Testbench for lc4_insn_mem_responder: directed scenarios plus randomized
// traffic, checked by a queue-based reference model and a negedge monitor.
// Honors LC4_IMEM_RESP_ADDR_EN when defined.
module tb_lc4_insn_mem_responder;

  localparam int L = 8;

  logic        clk;
  logic        rst;
  logic        gwe;
  logic        req_valid;
  logic [15:0] mem_iaddr;
  logic [15:0] mem_idata;
  logic        resp_valid;
  logic        ld_we;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;
`ifdef LC4_IMEM_RESP_ADDR_EN
  logic [15:0] resp_addr;
`endif

  lc4_insn_mem_responder #(.LATENCY(L), .ADDR_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .gwe        (gwe),
    .req_valid  (req_valid),
    .mem_iaddr  (mem_iaddr),
    .mem_idata  (mem_idata),
`ifdef LC4_IMEM_RESP_ADDR_EN
    .resp_addr  (resp_addr),
`endif
    .resp_valid (resp_valid),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] data;
    logic [15:0] addr;
  } sb_t;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic [15:0] addr;
  } obs_t;

  sb_t         sb_q[$];
  obs_t        obs_q[$];
  logic [15:0] ref_mem [int];
  int          gcount = 0;
  int          cyc = 0;
  bit          mon_en = 0;
  int          n_total = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: a word array plus a queue of responses, each due after
  // L gwe edges counted from (and including) its acceptance edge.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      sb_q.delete();
    end else if (gwe) begin
      gcount++;
      if (req_valid) begin
        sb_q.push_back('{due: gcount + L - 1,
                         data: ref_mem.exists(int'(mem_iaddr)) ? ref_mem[int'(mem_iaddr)] : 16'hxxxx,
                         addr: mem_iaddr});
      end
      if (ld_we) ref_mem[int'(ld_addr)] = ld_data;
    end
  end

  // Monitor: drop stale entries, compare outputs against the due entry.
  always @(negedge clk) begin
    if (mon_en) begin
      logic        exp_v;
      logic [15:0] exp_d;
      logic [15:0] exp_a;
      while (sb_q.size() > 0 && sb_q[0].due < gcount) void'(sb_q.pop_front());
      exp_v = 1'b0;
      exp_d = 16'h0;
      exp_a = 16'h0;
      if (sb_q.size() > 0 && sb_q[0].due == gcount) begin
        exp_v = 1'b1;
        exp_d = sb_q[0].data;
        exp_a = sb_q[0].addr;
      end
      check("resp_valid", 32'(resp_valid), 32'(exp_v));
      check("mem_idata", 32'(mem_idata), 32'(exp_d));
`ifdef LC4_IMEM_RESP_ADDR_EN
      check("resp_addr", 32'(resp_addr), 32'(exp_a));
      if (resp_valid) obs_q.push_back('{cyc: cyc, data: mem_idata, addr: resp_addr});
`else
      if (resp_valid) obs_q.push_back('{cyc: cyc, data: mem_idata, addr: 16'h0});
`endif
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; gwe = 1'b1; req_valid = 1'b0; ld_we = 1'b0;
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    idle();
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_we = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (L + 6) step();
  endtask

  task automatic check_obs(input string name, input int idx, input int c0,
                           input int exp_ofs, input logic [15:0] exp_d);
    if (idx < obs_q.size()) begin
      check({name, "_cycle"}, 32'(obs_q[idx].cyc - c0), 32'(exp_ofs));
      check({name, "_data"}, 32'(obs_q[idx].data), 32'(exp_d));
    end else begin
      check({name, "_present"}, 32'(obs_q.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int c0;
    clk = 1'b0; rst = 1'b1; gwe = 1'b0; req_valid = 1'b0; mem_iaddr = '0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;

    // Reset with gwe low: reset must still clear the pipeline.
    repeat (3) step();
    idle();
    mon_en = 1'b1;
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_mem_idata", 32'(mem_idata), 32'd0);

    for (int a = 0; a < 64; a++) load(16'(a), 16'($urandom));
    load(16'h0001, 16'h1111);
    load(16'h0002, 16'h2222);
    load(16'h0003, 16'h3333);
    load(16'h0010, 16'hA5A5);
    load(16'h0011, 16'h5A5A);
    load(16'h0020, 16'h0BAD);
    load(16'h1234, 16'h4321);
    drain();

    // Single request: response exactly L cycles later.
    obs_q.delete();
    c0 = cyc; req_valid = 1'b1; mem_iaddr = 16'h0010; step();
    drain();
    check("single_count", 32'(obs_q.size()), 32'd1);
    check_obs("single", 0, c0, 8, 16'hA5A5);

    // Back-to-back requests return in order on consecutive cycles.
    obs_q.delete();
    c0 = cyc;
    req_valid = 1'b1; mem_iaddr = 16'h0001; step();
    mem_iaddr = 16'h0002; step();
    mem_iaddr = 16'h0003; step();
    drain();
    check("b2b_count", 32'(obs_q.size()), 32'd3);
    check_obs("b2b0", 0, c0, 8, 16'h1111);
    check_obs("b2b1", 1, c0, 9, 16'h2222);
    check_obs("b2b2", 2, c0, 10, 16'h3333);

    // Stall cycles 3-5; requests and loads during the stall are ignored.
    obs_q.delete();
    c0 = cyc;
    req_valid = 1'b1; mem_iaddr = 16'h0010; step();
    idle(); step(); step();
    gwe = 1'b0; req_valid = 1'b1; ld_we = 1'b1; ld_addr = 16'h0010; ld_data = 16'hFFFF;
    repeat (3) step();
    idle();
    repeat (L + 8) step();
    check("stall_count", 32'(obs_q.size()), 32'd1);
    check_obs("stall", 0, c0, 11, 16'hA5A5);

    // Read and write of the same address on one edge returns old data.
    obs_q.delete();
    c0 = cyc;
    req_valid = 1'b1; mem_iaddr = 16'h0020; ld_we = 1'b1; ld_addr = 16'h0020; ld_data = 16'hC0DE;
    step();
    ld_we = 1'b0; step();
    drain();
    check("rw_count", 32'(obs_q.size()), 32'd2);
    check_obs("rw_old", 0, c0, 8, 16'h0BAD);
    check_obs("rw_new", 1, c0, 9, 16'hC0DE);

    // Reset discards in-flight requests; loader write on reset edge is dropped.
    obs_q.delete();
    req_valid = 1'b1; mem_iaddr = 16'h0001; step();
    mem_iaddr = 16'h0002; step();
    mem_iaddr = 16'h0003; step();
    idle(); step();
    rst = 1'b1; ld_we = 1'b1; ld_addr = 16'h0011; ld_data = 16'hDEAD; step();
    idle();
    repeat (L + 8) step();
    check("rst_no_resp", 32'(obs_q.size()), 32'd0);
    c0 = cyc;
    req_valid = 1'b1; mem_iaddr = 16'h0010; step();
    mem_iaddr = 16'h0011; step();
    drain();
    check("post_rst_count", 32'(obs_q.size()), 32'd2);
    check_obs("post_rst_a", 0, c0, 8, 16'hA5A5);
    check_obs("post_rst_b", 1, c0, 9, 16'h5A5A);

`ifdef LC4_IMEM_RESP_ADDR_EN
    obs_q.delete();
    c0 = cyc;
    req_valid = 1'b1; mem_iaddr = 16'h1234; step();
    drain();
    check("addr_count", 32'(obs_q.size()), 32'd1);
    check_obs("addr_resp", 0, c0, 8, 16'h4321);
    if (obs_q.size() > 0) check("addr_value", 32'(obs_q[0].addr), 32'h1234);
`endif

    // Randomized traffic with stalls, loads and occasional resets.
    for (int i = 0; i < 500; i++) begin
      gwe       = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      req_valid = 1'($urandom_range(0, 1));
      mem_iaddr = 16'($urandom_range(0, 63));
      ld_we     = ($urandom_range(0, 3) == 0);
      ld_addr   = 16'($urandom_range(0, 63));
      ld_data   = 16'($urandom);
      step();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
